// File: rtl/ascon_perm_ctrl.sv
// ascon_perm_ctrl: round sequencer and one-entry result buffer around the masked Ascon permutation core.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   in_valid / in_ready / in_shares     upstream shared 320*d-bit state handshake
//   core_in, core_sel1, core_sel2,      core input (zero outside the accept cycle) and core controls
//   core_sel_cst, core_done
//   core_out                            core shared result, valid in the CAPTURE cycle
//   out_valid / out_ready / out_shares  downstream buffered result handshake
//   busy                                permutation in progress
module ascon_perm_ctrl #(
    parameter int d  = 2,
    parameter int NR = 12,
    parameter int RL = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [320*d-1:0] in_shares,
    output logic [320*d-1:0] core_in,
    output logic             core_sel1,
    output logic             core_sel2,
    output logic             core_sel_cst,
    output logic             core_done,
    input  logic [320*d-1:0] core_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [320*d-1:0] out_shares,
    output logic             busy
);
    localparam logic [2:0] CYC_LAST = 3'(RL - 1);
    localparam logic [3:0] RND_LAST = 4'(NR - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, CAPTURE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       cycle_cnt_q, cycle_cnt_d;
    logic [3:0]       round_cnt_q, round_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [320*d-1:0] out_shares_q, out_shares_d;
    logic             accept;

    always_comb begin
        in_ready     = rst_n && state_q == IDLE && (!out_valid_q || out_ready);
        accept       = in_valid && in_ready;
        state_d      = state_q;
        cycle_cnt_d  = cycle_cnt_q;
        round_cnt_d  = round_cnt_q;
        core_sel1    = accept;
        core_sel2    = 1'b0;
        core_sel_cst = 1'b0;
        core_done    = 1'b0;
        case (state_q)
            IDLE: begin
                // The accept cycle doubles as cycle 0 of round 0 (parallel load of in_shares),
                // so RUN resumes at cycle 1.
                if (accept) begin
                    state_d     = RUN;
                    cycle_cnt_d = 3'd1;
                end
            end
            RUN: begin
                core_sel2    = cycle_cnt_q != 3'd0;
                core_sel_cst = cycle_cnt_q == 3'd1;
                if (cycle_cnt_q == CYC_LAST) begin
                    cycle_cnt_d = 3'd0;
                    round_cnt_d = round_cnt_q == RND_LAST ? 4'd0 : round_cnt_q + 4'd1;
                    state_d     = round_cnt_q == RND_LAST ? FLUSH : RUN;
                end else begin
                    cycle_cnt_d = cycle_cnt_q + 3'd1;
                end
            end
            FLUSH: begin
                core_done = 1'b1;
                state_d   = CAPTURE;
            end
            default: state_d = IDLE;
        endcase
        // Consumed results are zeroised so stale shares never linger in the buffer.
        out_valid_d  = state_q == CAPTURE ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
        out_shares_d = state_q == CAPTURE ? core_out : (out_valid_q && out_ready) ? '0 : out_shares_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cycle_cnt_q  <= 3'd0;
            round_cnt_q  <= 4'd0;
            out_valid_q  <= 1'b0;
            out_shares_q <= '0;
        end else begin
            state_q      <= state_d;
            cycle_cnt_q  <= cycle_cnt_d;
            round_cnt_q  <= round_cnt_d;
            out_valid_q  <= out_valid_d;
            out_shares_q <= out_shares_d;
        end
    end

    assign core_in    = accept ? in_shares : '0;
    assign out_valid  = out_valid_q;
    assign out_shares = out_shares_q;
    assign busy       = state_q != IDLE;

    assert property (@(posedge clk) disable iff (!rst_n) cycle_cnt_q <= CYC_LAST && round_cnt_q <= RND_LAST);
endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// tb_ascon_perm_ctrl: table-driven check of sequencing, buffering, backpressure and abort of ascon_perm_ctrl.
module tb_ascon_perm_ctrl;
    localparam int D   = 2;
    localparam int NR  = 12;
    localparam int W   = 320 * D;
    localparam int LAT = 6 * NR;

    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic         in_ready, core_sel1, core_sel2, core_sel_cst, core_done, out_valid, busy;
    logic [W-1:0] in_shares = '0, core_in, core_out, out_shares, lat;
    logic [W-1:0] r;
    int           errors = 0, checks = 0;

    typedef struct {
        logic [W-1:0] data;
        int           hold;
        int           abort;
        logic [W-1:0] exp;
    } vec_t;
    vec_t tv[6];

    always #5 clk = ~clk;

    ascon_perm_ctrl #(.d(D), .NR(NR), .RL(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_shares(in_shares),
        .core_in(core_in), .core_sel1(core_sel1), .core_sel2(core_sel2), .core_sel_cst(core_sel_cst),
        .core_done(core_done), .core_out(core_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_shares(out_shares), .busy(busy)
    );

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32+:32] = $urandom;
        return v;
    endfunction

    // Share-wise stand-in for the core's permutation: result differs from input and from junk.
    function automatic logic [W-1:0] xform(input logic [W-1:0] x);
        logic [W-1:0] y;
        logic [319:0] s;
        for (int i = 0; i < D; i++) begin
            s = x[i*320+:320];
            y[i*320+:320] = {s[318:0], s[319]} ^ {5{64'h0123_4567_89ab_cdef}};
        end
        return y;
    endfunction

    // Core model: latches core_in on load, presents the result only the cycle after core_done.
    always @(posedge clk) begin
        if (core_sel1) lat <= core_in;
        core_out <= core_done ? xform(lat) : rnd_w();
    end

    function automatic logic [6:0] ctrl();
        return {in_ready, core_sel1, core_sel2, core_sel_cst, core_done, busy, out_valid};
    endfunction

    // Expected controls at offset k from the accept cycle.
    function automatic logic [6:0] exp_ctrl(input int k, input logic pend);
        logic run;
        run = k >= 1 && k < LAT;
        return {k == 0, k == 0, run && k % 6 != 0, run && k % 6 == 1, k == LAT,
                k >= 1 && k <= LAT + 1, k == 0 ? pend : k == LAT + 2};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_c(input string name, input logic [6:0] act, input logic [6:0] exp);
        chk(name, W'(act), W'(exp));
    endtask

    task automatic do_txn(input int i);
        logic         pend;
        logic [W-1:0] prev;
        pend = i > 0 && tv[i-1].abort < 0;
        prev = pend ? tv[i-1].exp : '0;
        in_valid  = 1'b1;
        in_shares = tv[i].data;
        out_ready = pend;
        #1;
        chk_c($sformatf("ctrl accept t%0d", i), ctrl(), exp_ctrl(0, pend));
        chk($sformatf("core_in accept t%0d", i), core_in, tv[i].data);
        chk($sformatf("out_shares accept t%0d", i), out_shares, prev);
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
            if (k == tv[i].abort) begin
                rst_n = 1'b0;
                #1;
                chk_c($sformatf("ctrl abort t%0d", i), ctrl(), 7'b0);
                chk($sformatf("out_shares abort t%0d", i), out_shares, '0);
                chk($sformatf("core_in abort t%0d", i), core_in, '0);
                return;
            end
            #1;
            chk_c($sformatf("ctrl t%0d k=%0d", i, k), ctrl(), exp_ctrl(k, 1'b0));
            chk($sformatf("core_in t%0d k=%0d", i, k), core_in, '0);
            chk($sformatf("out_shares t%0d k=%0d", i, k), out_shares, k == LAT + 2 ? tv[i].exp : '0);
        end
        for (int h = 0; h < tv[i].hold; h++) begin
            @(negedge clk);
            #1;
            chk_c($sformatf("ctrl hold t%0d h=%0d", i, h), ctrl(), 7'b0000001);
            chk($sformatf("out_shares hold t%0d h=%0d", i, h), out_shares, tv[i].exp);
        end
    endtask

    initial begin
        r = rnd_w();
        tv[0].data = {r[319:0], r[319:0]};
        tv[1].data = '1;
        tv[2].data = rnd_w();
        tv[3].data = {20{32'hdead_beef}};
        tv[4].data = rnd_w();
        tv[5].data = rnd_w();
        tv[0].hold = 0;
        tv[1].hold = 100;
        tv[2].hold = 0;
        tv[3].hold = 2;
        tv[4].hold = 0;
        tv[5].hold = 0;
        for (int i = 0; i < 6; i++) begin
            tv[i].abort = i == 4 ? 30 : -1;
            tv[i].exp   = xform(tv[i].data);
        end

        in_valid  = 1'b1;
        in_shares = tv[0].data;
        #1;
        chk_c("ctrl in reset", ctrl(), 7'b0);
        chk("core_in in reset", core_in, '0);
        chk("out_shares in reset", out_shares, '0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk_c("ctrl after reset", ctrl(), 7'b1000000);
        chk("out_shares after reset", out_shares, '0);

        for (int i = 0; i < 5; i++) do_txn(i);

        @(negedge clk);
        #1;
        chk_c("ctrl held in reset", ctrl(), 7'b0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk_c("ctrl after abort", ctrl(), 7'b1000000);
        chk("out_shares after abort", out_shares, '0);
        do_txn(5);

        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk_c("ctrl final consume", ctrl(), 7'b1000001);
        @(negedge clk);
        #1;
        chk_c("ctrl drained", ctrl(), 7'b1000000);
        chk("out_shares drained", out_shares, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
